// File: rtl/snake_pkg.sv
// Shared types for the snake game blocks: FSM state encoding and the coordinate pair.
// Coordinates are held at COORD_MAX_W bits so one type serves every COORD_W up to that width.
package snake_pkg;

    localparam int COORD_MAX_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        REPORT,
        DEAD
    } state_t;

    typedef struct packed {
        logic [COORD_MAX_W-1:0] x;
        logic [COORD_MAX_W-1:0] y;
    } coord_t;

endpackage

// File: rtl/snake_body_store.sv
// Snake body storage: a shift register of coordinate pairs with one combinational read port.
// Segment 0 is the head; a shift pushes a new head and moves every segment one slot tailward.
module snake_body_store
    import snake_pkg::*;
#(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int GRID_H   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       shift_en,
    input  coord_t                     head_in,
    input  logic [$clog2(MAX_LEN)-1:0] rd_idx,
    output coord_t                     rd_data
);

    coord_t segs [MAX_LEN];

    // Reset lays the body out horizontally on the middle row, head rightmost.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                if (k < INIT_LEN) begin
                    segs[k].x <= COORD_MAX_W'(INIT_LEN - 1 - k);
                    segs[k].y <= COORD_MAX_W'(GRID_H / 2);
                end else begin
                    segs[k] <= '0;
                end
            end
        end else if (shift_en) begin
            segs[0] <= head_in;
            for (int k = 1; k < MAX_LEN; k++) begin
                segs[k] <= segs[k-1];
            end
        end
    end

    assign rd_data = segs[rd_idx];

endmodule

// File: rtl/snake_collision_engine.sv
// Snake collision engine: checks a candidate head against the walls and the body, then moves the body.
// Optional macro SNAKE_WRAP_EN turns the playfield into a torus (no walls, edge coordinates wrap).
module snake_collision_engine
    import snake_pkg::*;
#(
    parameter int COORD_W  = 4,
    parameter int GRID_W   = 8,
    parameter int GRID_H   = 8,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         step_valid,
    output logic                         step_ready,
    input  logic [COORD_W-1:0]           next_x,
    input  logic [COORD_W-1:0]           next_y,
    input  logic                         grow,
    output logic                         result_valid,
    output logic                         wall_hit,
    output logic                         self_hit,
    output logic                         dead,
    output logic [$clog2(MAX_LEN+1)-1:0] length
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = $clog2(MAX_LEN);

    state_t             state;
    coord_t             cand;
    logic               cand_grow;
    logic [IDX_W-1:0]   scan_idx;
    logic [IDX_W-1:0]   scan_last;
    logic [COORD_W-1:0] map_x;
    logic [COORD_W-1:0] map_y;
    logic               off_grid;
    logic [LEN_W-1:0]   scan_cnt;
    coord_t             seg_rd;
    logic               shift_en;

`ifdef SNAKE_WRAP_EN
    // One step past either edge lands on the opposite edge; all-ones is the -1 of a step left/up.
    always_comb begin
        map_x    = next_x;
        map_y    = next_y;
        off_grid = 1'b0;
        if (next_x == COORD_W'(GRID_W)) map_x = '0;
        else if (next_x == '1)          map_x = COORD_W'(GRID_W - 1);
        if (next_y == COORD_W'(GRID_H)) map_y = '0;
        else if (next_y == '1)          map_y = COORD_W'(GRID_H - 1);
    end
`else
    assign map_x    = next_x;
    assign map_y    = next_y;
    assign off_grid = (int'(next_x) >= GRID_W) || (int'(next_y) >= GRID_H);
`endif

    // The tail is skipped only when it moves away this step (no growth).
    assign scan_cnt = grow ? length : length - 1'b1;
    assign shift_en = (state == REPORT) && !wall_hit && !self_hit;

    snake_body_store #(
        .MAX_LEN  (MAX_LEN),
        .INIT_LEN (INIT_LEN),
        .GRID_H   (GRID_H)
    ) u_body (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .head_in  (cand),
        .rd_idx   (scan_idx),
        .rd_data  (seg_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            step_ready   <= 1'b1;
            result_valid <= 1'b0;
            wall_hit     <= 1'b0;
            self_hit     <= 1'b0;
            dead         <= 1'b0;
            length       <= LEN_W'(INIT_LEN);
            cand         <= '0;
            cand_grow    <= 1'b0;
            scan_idx     <= '0;
            scan_last    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (step_valid) begin
                        step_ready <= 1'b0;
                        cand.x     <= COORD_MAX_W'(map_x);
                        cand.y     <= COORD_MAX_W'(map_y);
                        cand_grow  <= grow;
                        scan_idx   <= '0;
                        scan_last  <= IDX_W'(scan_cnt - 1'b1);
                        if (off_grid) begin
                            state        <= REPORT;
                            result_valid <= 1'b1;
                            wall_hit     <= 1'b1;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (seg_rd == cand) begin
                        state        <= REPORT;
                        result_valid <= 1'b1;
                        self_hit     <= 1'b1;
                    end else if (scan_idx == scan_last) begin
                        state        <= REPORT;
                        result_valid <= 1'b1;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                // Growth saturates at MAX_LEN; the body store then simply drops the tail.
                REPORT: begin
                    result_valid <= 1'b0;
                    wall_hit     <= 1'b0;
                    self_hit     <= 1'b0;
                    if (wall_hit || self_hit) begin
                        state <= DEAD;
                        dead  <= 1'b1;
                    end else begin
                        state      <= IDLE;
                        step_ready <= 1'b1;
                        if (cand_grow && (length < LEN_W'(MAX_LEN))) begin
                            length <= length + 1'b1;
                        end
                    end
                end
                DEAD: begin
                    state <= DEAD;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
